// File: rtl/clock_phase_counter_array.sv
// NCHAN independent phase counters on the fast clock, each wrapping at a
// runtime-programmable ratio; new ratios take effect only at a wrap or on resync.
module clock_phase_counter_array #(
  parameter  int NCHAN        = 4,
  parameter  int NBITS        = 3,
  parameter  int RST_RATIO_M1 = 1,
  localparam int CW           = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                   clk,
  input  logic                   clk_reset_n,
  input  logic                   en,
  input  logic                   sync,
  input  logic                   cfg_val,
  output logic                   cfg_rdy,
  input  logic [CW-1:0]          cfg_chan,
  input  logic [NBITS-1:0]       cfg_ratio_m1,
  output logic [NCHAN*NBITS-1:0] cnt,
  output logic [NCHAN*NBITS-1:0] ratio_m1,
  output logic [NCHAN-1:0]       last,
  output logic [NCHAN-1:0]       pending
);

  localparam logic [NBITS-1:0] RST_VAL = NBITS'(RST_RATIO_M1);

  logic [NCHAN-1:0] sel;
  logic             xfer;

  // An out-of-range cfg_chan selects nothing, which also drops cfg_rdy.
  assign cfg_rdy = !sync && (|sel) && !(|(sel & pending));
  assign xfer    = cfg_val && cfg_rdy;

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    logic [NBITS-1:0] cnt_r;
    logic [NBITS-1:0] ratio_r;
    logic [NBITS-1:0] shadow_r;
    logic             pend_r;
    logic             wrap;
    logic             load;

    assign sel[g] = (int'(cfg_chan) == g);
    assign wrap   = (cnt_r == ratio_r);
    assign load   = xfer && sel[g];

    // A load can only land on a non-pending channel, and an apply only on a
    // pending one, so the two never compete for pend_r in the same cycle.
    // NOTE: every state bit, shadow included, is reset so no channel can start
    // with a stale ratio; non-blocking assignments keep all channels updating
    // from the same pre-edge values.
    always_ff @(posedge clk or negedge clk_reset_n) begin
      if (!clk_reset_n) begin
        cnt_r    <= RST_VAL;
        ratio_r  <= RST_VAL;
        shadow_r <= RST_VAL;
        pend_r   <= 1'b0;
      end else begin
        if (sync) begin
          if (pend_r) begin
            ratio_r <= shadow_r;
            cnt_r   <= shadow_r;
            pend_r  <= 1'b0;
          end else begin
            cnt_r <= ratio_r;
          end
        end else if (en) begin
          if (wrap) begin
            cnt_r <= '0;
            if (pend_r) begin
              ratio_r <= shadow_r;
              pend_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end

        if (load) begin
          shadow_r <= cfg_ratio_m1;
          pend_r   <= 1'b1;
        end
      end
    end

    assign cnt[g*NBITS +: NBITS]      = cnt_r;
    assign ratio_m1[g*NBITS +: NBITS] = ratio_r;
    assign last[g]                    = wrap;
    assign pending[g]                 = pend_r;
  end

endmodule
